// File: rtl/pio_bus_pkg.sv
// rtl/pio_bus_pkg.sv - shared types and PIO register map for the PIO bus master
// Contents: pio_cmd_t command record, bus_state_t FSM states, PIO register
// byte addresses and a helper sizing the busy-timeout counter.
package pio_bus_pkg;

    typedef struct packed {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] wdata;
    } pio_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } bus_state_t;

    localparam logic [11:0] CTRL          = 12'h000;
    localparam logic [11:0] INSTR_MEM0    = 12'h048;
    localparam logic [11:0] SM0_CLKDIV    = 12'h0C8;
    localparam logic [11:0] SM0_EXECCTRL  = 12'h0CC;
    localparam logic [11:0] SM0_SHIFTCTRL = 12'h0D0;
    localparam logic [11:0] SM0_ADDR      = 12'h0D4;
    localparam logic [11:0] SM0_INSTR     = 12'h0D8;

    localparam int CMD_W = $bits(pio_cmd_t);

    // A disabled timeout (0) still gets a 1-bit counter so no zero-width vector appears.
    function automatic int tmo_cnt_w(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pio_bus_master_if.sv
// rtl/pio_bus_master_if.sv - PIO register port between the bus master and the PIO
// Signals: sel, RW (1 = write), addr[11:0], wdata[31:0] from master;
// rdata[31:0], busy (stall) from the PIO slave.
interface pio_bus_master_if;
    logic        sel;
    logic        RW;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    modport master (output sel, RW, addr, wdata, input rdata, busy);
    modport slave  (input sel, RW, addr, wdata, output rdata, busy);
endinterface

// File: rtl/pio_cmd_fifo.sv
// rtl/pio_cmd_fifo.sv - synchronous command FIFO with full/empty flags
// Ports: clk, resetn (sync active-low), push/wdata write side, pop/rdata
// read side (rdata shows the head entry), full, empty.
module pio_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra bit so equal low bits can be told apart as full vs empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pio_bus_master.sv
// rtl/pio_bus_master.sv - queued register-bus initiator driving the PIO slave port
// Ports: clk, reset (sync active-low); cmd_valid/cmd_ready/cmd_rw/cmd_addr/
// cmd_wdata command input; rsp_valid/rsp_ready/rsp_rdata/rsp_err response
// output; bus (master modport: sel, RW, addr, wdata, rdata, busy); idle.
module pio_bus_master
    import pio_bus_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [11:0]              cmd_addr,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    pio_bus_master_if.master         bus,
    output logic                     idle
);
    localparam int             CW  = tmo_cnt_w(TIMEOUT);
    localparam logic [CW:0]    TMO = (CW+1)'(TIMEOUT);

    bus_state_t  state;
    pio_cmd_t    push_cmd;
    pio_cmd_t    head_cmd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [CW-1:0] tmo_cnt;
    logic [CW:0]   tmo_next;
    logic          tmo_hit;

    assign push_cmd  = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
    // No pop-through: readiness depends only on the full flag, and is held low in reset.
    assign cmd_ready = !fifo_full && reset;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign idle      = (state == IDLE) && fifo_empty;

    // Value the counter takes on this busy edge; the abort fires on the TIMEOUT-th one.
    assign tmo_next = {1'b0, tmo_cnt} + (CW+1)'(1);
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_next == TMO);

    pio_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (reset),
        .push   (cmd_valid && cmd_ready),
        .wdata  (push_cmd),
        .pop    (fifo_pop),
        .rdata  (head_cmd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bus.sel   <= 1'b0;
            bus.RW    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        bus.RW    <= head_cmd.rw;
                        bus.addr  <= head_cmd.addr;
                        bus.wdata <= head_cmd.wdata;
                        bus.sel   <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!bus.busy) begin
                        rsp_rdata <= bus.RW ? 32'h0 : bus.rdata;
                        rsp_err   <= 1'b0;
                        bus.sel   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        if (tmo_cnt != '1) begin
                            tmo_cnt <= tmo_next[CW-1:0];
                        end
                        if (tmo_hit) begin
                            bus.sel   <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_bus_master.sv
// tb/tb_pio_bus_master.sv - self-checking bench for pio_bus_master
module tb_pio_bus_master;
    import pio_bus_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        idle;

    pio_bus_master_if bus();

    pio_bus_master #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          busy;
        logic [31:0] slv;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: commands accepted but not yet on the bus, responses owed.
    pio_cmd_t cmd_q[$];
    rsp_t     rsp_q[$];
    int       rise_t[$];

    // PIO slave / environment controls.
    int          plan[$];
    int          fixed_busy = 0;
    logic [31:0] fixed_rdata = 32'h0;
    logic        rnd_mode = 1'b0;
    int          rsp_mode = 0;
    int          cur_busy = 0;
    logic [31:0] cur_rdata = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rw, input logic [11:0] a, input logic [31:0] d);
        int n = 0;
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("cmd_accept_bound", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rsp_valid && lat < 100);
        chk("rsp_arrives", rsp_valid, 1);
    endtask

    // PIO slave: busy for the first cur_busy edges of each access, then done.
    initial begin : env
        int acc_n = 0;
        bus.busy  = 1'b0;
        bus.rdata = 32'h0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rsp_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom % 4) != 0;
            endcase
            if (bus.sel) begin
                if (acc_n == 0) begin
                    if (plan.size() > 0)  cur_busy = plan.pop_front();
                    else if (rnd_mode)    cur_busy = $urandom_range(0, 10);
                    else                  cur_busy = fixed_busy;
                    cur_rdata = rnd_mode ? $urandom : fixed_rdata;
                    bus.rdata = cur_rdata;
                end
                bus.busy = (acc_n < cur_busy);
                acc_n++;
            end else begin
                acc_n    = 0;
                bus.busy = 1'b0;
            end
        end
    end

    // Scoreboard: ordering, bus contents, access length, response values and holds.
    initial begin : monitor
        pio_cmd_t    c;
        pio_cmd_t    lat_bus;
        rsp_t        r;
        rsp_t        e;
        rsp_t        pend_val;
        logic        prev_sel = 1'b0;
        logic        pend = 1'b0;
        int          sel_cnt = 0;
        int          exp_len = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("cmd_ready_in_reset", cmd_ready, 0);
                cmd_q.delete();
                rsp_q.delete();
                prev_sel = 1'b0;
                pend     = 1'b0;
            end else begin
                if (bus.sel && !prev_sel) begin
                    rise_t.push_back(cyc);
                    chk("access_has_cmd", cmd_q.size() > 0, 1);
                    c = '{rw: 1'b0, addr: 12'h0, wdata: 32'h0};
                    if (cmd_q.size() > 0) begin
                        c = cmd_q.pop_front();
                        chk("bus_rw", bus.RW, c.rw);
                        chk("bus_addr", bus.addr, c.addr);
                        chk("bus_wdata", bus.wdata, c.wdata);
                    end
                    lat_bus = '{rw: bus.RW, addr: bus.addr, wdata: bus.wdata};
                    if (cur_busy >= TMO) begin
                        r = '{err: 1'b1, rdata: 32'h0};
                        exp_len = TMO;
                    end else begin
                        r = '{err: 1'b0, rdata: c.rw ? 32'h0 : cur_rdata};
                        exp_len = cur_busy + 1;
                    end
                    rsp_q.push_back(r);
                    sel_cnt = 1;
                end else if (bus.sel) begin
                    sel_cnt++;
                    chk("bus_stable", {bus.RW, bus.addr, bus.wdata}, lat_bus);
                end
                if (!bus.sel && prev_sel) chk("sel_cycles", sel_cnt, exp_len);
                if (bus.sel) chk("no_sel_during_rsp", rsp_valid, 0);
                prev_sel = bus.sel;
                chk("cmd_ready_vs_full", cmd_ready, cmd_q.size() < DEPTH);
                if (cmd_valid && cmd_ready)
                    cmd_q.push_back('{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata});
                if (pend) begin
                    chk("rsp_hold_valid", rsp_valid, 1);
                    chk("rsp_hold_data", {rsp_err, rsp_rdata}, pend_val);
                end
                pend = 1'b0;
                if (rsp_valid) begin
                    if (rsp_ready) begin
                        chk("rsp_expected", rsp_q.size() > 0, 1);
                        if (rsp_q.size() > 0) begin
                            e = rsp_q.pop_front();
                            chk("rsp_rdata", rsp_rdata, e.rdata);
                            chk("rsp_err", rsp_err, e.err);
                        end
                    end else begin
                        pend     = 1'b1;
                        pend_val = '{err: rsp_err, rdata: rsp_rdata};
                    end
                end
            end
        end
    end

    initial begin : stim
        vec_t tv[7];
        int   lat;
        int   n;
        logic seen;
        logic [9:0] wa;

        tv[0] = '{1'b1, CTRL,          32'h0000_0001, 0,   32'h0,         32'h0,         1'b0, 2};
        tv[1] = '{1'b0, SM0_CLKDIV,    32'h0,         3,   32'h0001_0000, 32'h0001_0000, 1'b0, 5};
        tv[2] = '{1'b0, SM0_ADDR,      32'h0,         0,   32'h0000_001F, 32'h0000_001F, 1'b0, 2};
        tv[3] = '{1'b1, SM0_EXECCTRL,  32'h1234_5678, 7,   32'hFFFF_FFFF, 32'h0,         1'b0, 9};
        tv[4] = '{1'b0, SM0_SHIFTCTRL, 32'h0,         8,   32'h0000_DEAD, 32'h0,         1'b1, 9};
        tv[5] = '{1'b0, SM0_INSTR,     32'h0,         20,  32'hCAFE_0000, 32'h0,         1'b1, 9};
        tv[6] = '{1'b1, SM0_INSTR,     32'h0000_E081, 2,   32'h0,         32'h0,         1'b0, 4};

        reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) tick();
        chk("rst_sel", bus.sel, 0);
        chk("rst_rw", bus.RW, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_idle", idle, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Table-driven single accesses: latency from push edge to rsp_valid.
        rsp_mode = 1;
        for (int i = 0; i < 7; i++) begin
            fixed_busy  = tv[i].busy;
            fixed_rdata = tv[i].slv;
            send_cmd(tv[i].rw, tv[i].addr, tv[i].wdata);
            wait_rsp(lat);
            chk($sformatf("vec%0d_latency", i), lat, tv[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rsp_rdata, tv[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), rsp_err, tv[i].exp_err);
            repeat (3) tick();
        end
        chk("idle_after_table", idle, 1);

        // Back-to-back writes: accesses 3 cycles apart.
        fixed_busy = 0;
        rise_t.delete();
        for (int k = 0; k < 5; k++) send_cmd(1'b1, INSTR_MEM0 + 12'(4 * k), 32'h100 + 32'(k));
        n = 0;
        while (rise_t.size() < 5 && n < 100) begin tick(); n++; end
        repeat (4) tick();
        chk("b2b_count", rise_t.size(), 5);
        for (int k = 1; k < 5 && k < rise_t.size(); k++)
            chk($sformatf("b2b_spacing%0d", k), rise_t[k] - rise_t[k-1], 3);

        // Timeout followed by a normal queued command.
        plan.push_back(100);
        plan.push_back(0);
        send_cmd(1'b0, SM0_CLKDIV, 32'h0);
        send_cmd(1'b1, SM0_ADDR, 32'h0000_0005);
        wait_rsp(lat);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_rdata", rsp_rdata, 0);
        wait_rsp(lat);
        chk("after_tmo_latency", lat, 3);
        chk("after_tmo_err", rsp_err, 0);
        repeat (3) tick();

        // Response back-pressure with the FIFO filled behind it.
        rsp_mode    = 0;
        fixed_busy  = 0;
        fixed_rdata = 32'hA5A5_0001;
        send_cmd(1'b0, SM0_CLKDIV, 32'h0);
        for (int k = 0; k < 4; k++) send_cmd(1'b1, INSTR_MEM0 + 12'(4 * k), 32'h200 + 32'(k));
        wait_rsp(lat);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_sel", bus.sel, 0);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, 32'hA5A5_0001);
            chk("hold_full", cmd_ready, 0);
        end
        rsp_mode = 1;
        wait_rsp(lat);
        chk("release_latency", lat, 3);
        chk("release_rdata", rsp_rdata, 0);
        n = 0;
        while (!(idle && !rsp_valid) && n < 200) begin tick(); n++; end
        chk("hold_drain_idle", idle, 1);

        // Reset while an access is stuck busy with two commands queued.
        plan.push_back(100);
        send_cmd(1'b0, SM0_ADDR, 32'h0);
        send_cmd(1'b1, CTRL, 32'h3);
        send_cmd(1'b1, CTRL, 32'h7);
        chk("pre_rst_sel", bus.sel, 1);
        reset = 1'b0;
        tick();
        chk("mid_rst_sel", bus.sel, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        reset = 1'b1;
        plan.delete();
        tick();
        chk("after_rst_idle", idle, 1);
        chk("after_rst_cmd_ready", cmd_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.sel || rsp_valid) seen = 1'b1;
        end
        chk("after_rst_quiet", seen, 0);

        // Randomised traffic against the scoreboard.
        rnd_mode = 1'b1;
        rsp_mode = 2;
        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            wa = 10'($urandom);
            send_cmd(1'($urandom), {wa, 2'b00}, $urandom);
        end
        rsp_mode = 1;
        n = 0;
        while (!(idle && !rsp_valid && cmd_q.size() == 0) && n < 3000) begin tick(); n++; end
        repeat (3) tick();
        chk("rnd_idle", idle, 1);
        chk("rnd_cmd_q_empty", cmd_q.size(), 0);
        chk("rnd_rsp_q_empty", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_bus_master.md
# pio_bus_master

Register-bus initiator for the PIO block. It accepts queued read/write commands from a controller, such as a boot sequencer, a test harness or a CPU bridge. For each command it drives the PIO register port (`sel`, `RW`, `addr`, `wdata`), waits out `busy`, and returns one response per command. It is the other end of the PIO's slave register interface. Typical uses are loading instruction memory, programming clock dividers and exec/shift control, and enabling state machines.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TIMEOUT`, 255: maximum number of consecutive `busy` cycles before the access is aborted; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO can accept.
- `cmd_rw`  in  1  1 = write, 0 = read (same encoding as the PIO `RW`).
- `cmd_addr`  in  12  PIO register byte address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  read data; 0 for writes and for timeouts.
- `rsp_err`  out  1  access timed out.
- `sel`  out  1  bus select to the PIO.
- `RW`  out  1  bus direction.
- `addr`  out  12  bus address.
- `wdata`  out  32  bus write data.
- `rdata`  in  32  bus read data from the PIO.
- `busy`  in  1  PIO stall.
- `idle`  out  1  FIFO empty and FSM in IDLE.

## Operation
- Command FIFO, DEPTH x 45 bits (`rw`, `addr`, `wdata`).
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. There is no pop-through: a full FIFO refuses a push even when a pop happens in the same cycle.
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - If the FIFO is non-empty: pop it, register `RW`/`addr`/`wdata`, set `sel=1`, clear the timeout counter, and go to ACCESS.
- ACCESS (`sel=1`, bus outputs held stable):
  - At a clock edge with `busy=0`, the access completes.
    - Read: `rsp_rdata <= rdata`.
    - Write: `rsp_rdata <= 0`.
    - Also `rsp_err <= 0`, `sel <= 0`, `rsp_valid <= 1`, go to RESP.
  - At an edge with `busy=1`, the counter increments. When the counter reaches TIMEOUT (TIMEOUT != 0): `sel <= 0`, `rsp_err <= 1`, `rsp_rdata <= 0`, `rsp_valid <= 1`, go to RESP.
  - The counter is `$clog2(TIMEOUT+1)` bits wide and saturates.
- RESP:
  - Hold `rsp_*` stable while `rsp_ready=0`.
  - On `rsp_ready=1`: `rsp_valid <= 0`, go to IDLE.
- `RW`/`addr`/`wdata` keep their last values while `sel=0`. The PIO ignores them in that state.
- Responses return strictly in command order. Exactly one response is produced per accepted command.

## Timing
- Reset (sampled `reset==0` at an edge):
  - FIFO emptied; state IDLE.
  - `sel=0`, `RW=0`, `addr=0`, `wdata=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `idle=1`.
  - `cmd_ready=0` while `reset` is low.
- Reset during ACCESS or RESP:
  - `sel` drops at that edge.
  - The in-flight command and all queued commands are discarded; no response is produced.
- Latency:
  - Command pushed at edge N.
  - `sel` high from edge N+1.
  - With `busy=0`, `rsp_valid` high from edge N+2.
  - Each `busy` cycle adds one cycle.
- Back-to-back throughput:
  - RESP is accepted at edge M; IDLE at edge M pops the next command, so `sel` is high again from edge M+1.
  - Sustained rate is one access per 3 cycles with `rsp_ready` tied high.
- A push and a pop in the same cycle leave the FIFO count unchanged.
- Timeout: with `busy` stuck high, the abort edge is the TIMEOUT-th busy edge in ACCESS.
- `idle` is combinational: `(state==IDLE) && empty`.

## Structure
- Package `pio_bus_pkg`:
  - `pio_cmd_t` struct (`rw`, `addr[11:0]`, `wdata[31:0]`).
  - State enum `{IDLE, ACCESS, RESP}`.
  - PIO register address constants:
    - CTRL 0x000
    - INSTR_MEM0 0x048
    - SM0_CLKDIV 0x0C8
    - SM0_EXECCTRL 0x0CC
    - SM0_SHIFTCTRL 0x0D0
    - SM0_ADDR 0x0D4
    - SM0_INSTR 0x0D8
- Sub-module `pio_cmd_fifo`: parameterised synchronous FIFO with `full`/`empty`, read/write pointers one bit wider than the address for wrap detection.
- Top `pio_bus_master` holds the FSM, bus registers and timeout counter. It is instantiated beside `pio`, with its bus outputs wired to the PIO register port.

## Test plan
- Write 0x0000_0001 to CTRL (0x000) with `busy=0` → `sel` for exactly 1 cycle with `RW=1`, `addr=0x000`, `wdata=1`; response `rsp_rdata=0`, `rsp_err=0` at N+2.
- Read SM0_CLKDIV (0x0C8); the PIO holds `busy=1` for 3 cycles and then returns 0x0001_0000 → `sel` high for 4 cycles; `rsp_rdata=0x0001_0000`.
- Push 5 writes (INSTR_MEM0 + 4k) with `rsp_ready=1`, DEPTH=4 → `cmd_ready` low exactly while the FIFO is full; all 5 accesses appear in order, 3 cycles apart.
- `busy` stuck high, TIMEOUT=8 → `sel` drops after 8 busy edges; `rsp_err=1`, `rsp_rdata=0`; the next queued command still executes.
- `rsp_ready` held low for 10 cycles after a read → `rsp_*` stable; no new `sel` until the response is taken.
- Assert `reset=0` during ACCESS with 2 commands queued → `sel=0` at the next edge, no response, `idle=1` and `cmd_ready=1` the cycle after `reset` returns high.
